// File: rtl/avalon_bus_master.sv
// Avalon-MM master front end: round-robin arbitration between fetch and load/store clients.
// Optional waitrequest timeout abort is enabled by defining BUS_TIMEOUT_EN.
module avalon_bus_master #(
    parameter bit ADDR_WORD      = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        bus_err,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    // state | meaning
    // IDLE  | bus quiet, arbitrate pending requests
    // XFER  | read/write on the bus, waiting for waitrequest low
    // DONE  | one-cycle done strobe to the granted client
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_q, state_d;
    logic        last_data_q;
    logic        grant_data_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] fetch_rdata_q;
    logic [31:0] data_rdata_q;
    logic        any_req;
    logic        pick_data;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign any_req   = fetch_req | data_req;
    // data wins only if fetch is idle or fetch had the previous grant
    assign pick_data = data_req & (~fetch_req | ~last_data_q);

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt_q;
    logic          err_q;

    assign timeout_hit = (state_q == XFER) && avm_waitrequest &&
                         (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == XFER && avm_waitrequest) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = XFER;
            XFER:    if (!avm_waitrequest || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        avm_read   = (state_q == XFER) && !we_q;
        avm_write  = (state_q == XFER) &&  we_q;
        fetch_done = (state_q == DONE) && !grant_data_q;
        data_done  = (state_q == DONE) &&  grant_data_q;
`ifdef BUS_TIMEOUT_EN
        bus_err    = (state_q == DONE) && err_q;
`else
        bus_err    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_data_q   <= 1'b1;
            grant_data_q  <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                grant_data_q <= pick_data;
                last_data_q  <= pick_data;
                if (pick_data) begin
                    addr_q  <= data_addr & ~32'h3;
                    be_q    <= data_be;
                    wdata_q <= data_wdata;
                    we_q    <= data_we;
                end else begin
                    addr_q  <= fetch_addr & ~32'h3;
                    be_q    <= 4'b1111;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                end
            end
            if (state_q == XFER && !we_q) begin
                if (!avm_waitrequest) begin
                    if (grant_data_q) data_rdata_q  <= avm_readdata;
                    else              fetch_rdata_q <= avm_readdata;
                end else if (timeout_hit) begin
                    if (grant_data_q) data_rdata_q  <= 32'hDEAD_BEEF;
                    else              fetch_rdata_q <= 32'hDEAD_BEEF;
                end
            end
        end
    end

    assign avm_address    = ADDR_WORD ? (addr_q >> 2) : addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;
    assign fetch_rdata    = fetch_rdata_q;
    assign data_rdata     = data_rdata_q;

endmodule

// File: doc/avalon_bus_master.md
Name: avalon_bus_master

Overview:
Avalon-MM master front end for the CPU core. It arbitrates between the instruction-fetch client and the load/store client, issues one Avalon read or write at a time to RAM_avalon, and honours waitrequest. It returns read data and a one-cycle done strobe to the client that was granted.

Parameters:
ADDR_WORD, 1, 1: avm_address = client byte address >> 2 (word index); 0: avm_address = byte address with bits [1:0] forced to 0
TIMEOUT_CYCLES, 255, maximum waitrequest-high cycles in XFER before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch read request; held high until fetch_done
fetch_addr  in  32  fetch byte address
fetch_done  out  1  one-cycle pulse: fetch_rdata valid
fetch_rdata  out  32  fetched word
data_req  in  1  load/store request; held high until data_done
data_we  in  1  1 = write, 0 = read
data_addr  in  32  load/store byte address
data_be  in  4  byte enables
data_wdata  in  32  store data
data_done  out  1  one-cycle pulse: transaction complete, data_rdata valid for reads
data_rdata  out  32  load data
bus_err  out  1  timeout flag, valid together with a done pulse
avm_address  out  32  Avalon address
avm_byteenable  out  4  Avalon byte enables
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  Avalon write data
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  slave read data

Behaviour:
- Clocking and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE; avm_read=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0; fetch_done=0, data_done=0, fetch_rdata=0, data_rdata=0, bus_err=0; last_grant=DATA, so fetch wins the first tie.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). No done pulse is issued for the aborted transaction.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - Nothing is driven on the bus.
  - On a rising edge with one or more requests pending, choose the grant: a single requester wins; if both request, the client not granted last wins (round-robin).
  - Latch address, byteenable, writedata and direction from the winner. Fetch always uses byteenable=4'b1111 and is always a read.
  - Update last_grant and go to XFER.
- XFER:
  - avm_read or avm_write is high.
  - avm_address, avm_byteenable and avm_writedata are held constant for the whole state.
  - On a rising edge with avm_waitrequest=0: the transaction completes. For a read, capture avm_readdata into the granted client's rdata register. Deassert avm_read/avm_write and go to DONE.
  - While avm_waitrequest=1: hold the request unchanged.
- DONE:
  - The granted client's done is high for exactly this one cycle; the other done stays 0.
  - rdata holds its value until that client's next completion.
  - The client must drop req on the edge that ends DONE.
  - Next state is always IDLE, giving one idle bus cycle between transactions.
- Latency: req first sampled at edge N → read/write asserted after edge N → done high after edge N+1+W, where W = number of waitrequest-high edges. Minimum request-to-done is 2 edges.
- A request arriving during XFER or DONE waits; it is never dropped.
- A client whose req is still high in IDLE after its own DONE is treated as a new request.
- Address conversion follows ADDR_WORD. Address bits [1:0] are ignored; misalignment is not checked.
- Both clients requesting continuously get strict alternation: F, D, F, D...

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - A counter clears on entry to XFER and increments on each edge with avm_waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES, drop avm_read/avm_write and go to DONE with bus_err=1.
  - For a read, the client's rdata is set to 32'hDEADBEEF.
  - bus_err is high only in that DONE cycle.
- Not defined: no counter; bus_err is tied to 0; XFER waits indefinitely.

Test Plan:
- Zero-wait fetch: fetch_req=1, fetch_addr=32'h0000_0010, waitrequest=0, readdata=32'hCAFE0001 → avm_address=4, avm_read high 1 cycle, fetch_done pulses 2 edges after req, fetch_rdata=32'hCAFE0001.
- Stalled store: data_we=1, data_addr=32'h20, data_be=4'b0011, data_wdata=32'h1234ABCD, waitrequest high 3 edges → avm_write/address/writedata stable 4 cycles, data_done one pulse, bus_err=0.
- Contention: both req high continuously after reset → grants F, D, F, D; exactly one done per DONE cycle; never both.
- Request during busy: data_req rises mid-fetch XFER → serviced right after the fetch's DONE+IDLE; not lost.
- Reset mid-XFER: reset_n=0 while avm_read=1 → avm_read=0 immediately, no done pulse; a fresh request after release completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck at 1 → read dropped after 8 stalled edges, data_done=1, bus_err=1, data_rdata=32'hDEADBEEF.
